// File: rtl/snoop_ac_queue.sv
// snoop_ac_queue
//   Buffers ACE snoop requests (AC channel) from the interconnect in a small
//   circular FIFO and hands them one at a time to the snoop cache controller.
//   Only one snoop is in flight at a time: the next head is not issued until
//   the CR response (and the CD data, if dataTransfer was set) has been seen
//   on the monitored response channels.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                cache flush in progress, holds off new issues
//   ac_valid_i/ac_ready_o  AC handshake; ac_addr_i, ac_snoop_i, ac_prot_i payload
//   snp_valid_o/snp_ready_i  request to snoop controller; snp_addr_o,
//                          snp_snoop_o, snp_prot_o head payload
//   cr_valid_i, cr_ready_i, cr_data_transfer_i   monitored CR handshake
//   cd_valid_i, cd_ready_i, cd_last_i            monitored CD handshake
//   mshr_addr_o            head address [55:0] for the MSHR alias check
//   mshr_addr_matches_i    MSHR holds the head line, holds off new issues
//   busy_o                 snoop in flight or queue non-empty
//   count_o                FIFO occupancy
//
// state   | meaning
// IDLE    | nothing in flight; issue head when allowed
// ISSUE   | snp_valid_o high with head fields, waiting for snp_ready_i
// WAIT_CR | head popped, waiting for the CR handshake
// WAIT_CD | dataTransfer set, waiting for the last CD beat

module snoop_ac_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AW-1:0]              ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  input  logic [2:0]                 ac_prot_i,
  output logic                       snp_valid_o,
  input  logic                       snp_ready_i,
  output logic [AW-1:0]              snp_addr_o,
  output logic [3:0]                 snp_snoop_o,
  output logic [2:0]                 snp_prot_o,
  input  logic                       cr_valid_i,
  input  logic                       cr_ready_i,
  input  logic                       cr_data_transfer_i,
  input  logic                       cd_valid_i,
  input  logic                       cd_ready_i,
  input  logic                       cd_last_i,
  output logic [55:0]                mshr_addr_o,
  input  logic                       mshr_addr_matches_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("snoop_ac_queue: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_CR = 2'd2,
    WAIT_CD = 2'd3
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_mem  [DEPTH];
  logic [3:0]      snoop_mem [DEPTH];
  logic [2:0]      prot_mem  [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            ready_q;
  logic            push;
  logic            pop;
  logic            issue;
  logic [AW-1:0]   head_addr;
  logic [55:0]     head_line;

  // ready is registered so that it reads 0 while in reset and only rises in
  // the cycle after release; it never depends on a same-cycle pop.
  assign push  = ac_valid_i && ready_q;
  assign issue = (state_q == ISSUE);
  assign pop   = issue && snp_ready_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < CW'(DEPTH));
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case (state_q)
        IDLE: begin
          if ((count_q != '0) && !flush_i && !mshr_addr_matches_i) begin
            state_q <= ISSUE;
          end
        end
        // flush/alias are only gates for entering ISSUE; once offered the
        // request stays up until the controller takes it.
        ISSUE: begin
          if (snp_ready_i) begin
            state_q <= WAIT_CR;
          end
        end
        WAIT_CR: begin
          if (cr_valid_i && cr_ready_i) begin
            state_q <= cr_data_transfer_i ? WAIT_CD : IDLE;
          end
        end
        WAIT_CD: begin
          if (cd_valid_i && cd_ready_i && cd_last_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is not reset: pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= ac_addr_i;
      snoop_mem[wr_ptr_q] <= ac_snoop_i;
      prot_mem[wr_ptr_q]  <= ac_prot_i;
    end
  end

  assign head_addr = addr_mem[rd_ptr_q];

  if (AW >= 56) begin : g_line_wide
    assign head_line = head_addr[55:0];
  end else begin : g_line_narrow
    assign head_line = 56'(head_addr);
  end

  // Head fields are gated so stale or uninitialised storage never shows.
  assign ac_ready_o  = ready_q;
  assign snp_valid_o = issue;
  assign snp_addr_o  = issue ? head_addr : '0;
  assign snp_snoop_o = issue ? snoop_mem[rd_ptr_q] : 4'h0;
  assign snp_prot_o  = issue ? prot_mem[rd_ptr_q] : 3'h0;
  assign mshr_addr_o = (count_q != '0) ? head_line : 56'h0;
  assign busy_o      = (state_q != IDLE) || (count_q != '0);
  assign count_o     = count_q;

endmodule

// File: tb/tb_snoop_ac_queue.sv
module tb_snoop_ac_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 64;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          ac_valid_i;
  logic          ac_ready_o;
  logic [AW-1:0] ac_addr_i;
  logic [3:0]    ac_snoop_i;
  logic [2:0]    ac_prot_i;
  logic          snp_valid_o;
  logic          snp_ready_i;
  logic [AW-1:0] snp_addr_o;
  logic [3:0]    snp_snoop_o;
  logic [2:0]    snp_prot_o;
  logic          cr_valid_i;
  logic          cr_ready_i;
  logic          cr_data_transfer_i;
  logic          cd_valid_i;
  logic          cd_ready_i;
  logic          cd_last_i;
  logic [55:0]   mshr_addr_o;
  logic          mshr_addr_matches_i;
  logic          busy_o;
  logic [2:0]    count_o;

  int checks   = 0;
  int failures = 0;
  int vcycles  = 0;
  logic [70:0] sb [$];

  always #5 clk = ~clk;

  snoop_ac_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .ac_valid_i          (ac_valid_i),
    .ac_ready_o          (ac_ready_o),
    .ac_addr_i           (ac_addr_i),
    .ac_snoop_i          (ac_snoop_i),
    .ac_prot_i           (ac_prot_i),
    .snp_valid_o         (snp_valid_o),
    .snp_ready_i         (snp_ready_i),
    .snp_addr_o          (snp_addr_o),
    .snp_snoop_o         (snp_snoop_o),
    .snp_prot_o          (snp_prot_o),
    .cr_valid_i          (cr_valid_i),
    .cr_ready_i          (cr_ready_i),
    .cr_data_transfer_i  (cr_data_transfer_i),
    .cd_valid_i          (cd_valid_i),
    .cd_ready_i          (cd_ready_i),
    .cd_last_i           (cd_last_i),
    .mshr_addr_o         (mshr_addr_o),
    .mshr_addr_matches_i (mshr_addr_matches_i),
    .busy_o              (busy_o),
    .count_o             (count_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepted pushes and compare every issued request,
  // both sampled at the falling edge where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (ac_valid_i && ac_ready_o) sb.push_back({ac_addr_i, ac_snoop_i, ac_prot_i});
      if (snp_valid_o) vcycles++;
      if (snp_valid_o && snp_ready_i) begin
        if (sb.size() == 0) begin
          check("issue_without_push", 1'b1, 1'b0);
        end else begin
          check("issue_order", {snp_addr_o, snp_snoop_o, snp_prot_o}, sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [3:0] s, input logic [2:0] p);
    bit acc = 1'b0;
    int n = 0;
    ac_valid_i = 1'b1;
    ac_addr_i  = a;
    ac_snoop_i = s;
    ac_prot_i  = p;
    do begin
      acc = ac_ready_o;
      tick();
      n++;
    end while (!acc && n < 50);
    ac_valid_i = 1'b0;
    if (!acc) check("push_timeout", acc, 1'b1);
  endtask

  task automatic cr_done(input logic dt);
    cr_valid_i = 1'b1;
    cr_ready_i = 1'b1;
    cr_data_transfer_i = dt;
    tick();
    cr_valid_i = 1'b0;
    cr_data_transfer_i = 1'b0;
  endtask

  task automatic cd_beat(input logic last);
    cd_valid_i = 1'b1;
    cd_ready_i = 1'b1;
    cd_last_i  = last;
    tick();
    cd_valid_i = 1'b0;
    cd_last_i  = 1'b0;
  endtask

  task automatic serve(input logic dt);
    int n = 0;
    snp_ready_i = 1'b1;
    while (!snp_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!snp_valid_o) check("issue_timeout", snp_valid_o, 1'b1);
    tick();
    cr_done(dt);
    if (dt) cd_beat(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; ac_valid_i = 1'b0; ac_addr_i = '0;
    ac_snoop_i = '0; ac_prot_i = '0; snp_ready_i = 1'b0; cr_valid_i = 1'b0;
    cr_ready_i = 1'b0; cr_data_transfer_i = 1'b0; cd_valid_i = 1'b0;
    cd_ready_i = 1'b0; cd_last_i = 1'b0; mshr_addr_matches_i = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_ac_ready", ac_ready_o, 1'b0);
    check("rst_snp_valid", snp_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_count", count_o, 3'd0);
    check("rst_mshr", mshr_addr_o, 56'h0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_ac_ready", ac_ready_o, 1'b1);

    // Single ReadShared with two CD beats
    vcycles = 0;
    snp_ready_i = 1'b1;
    push(64'h8000_1040, 4'h1, 3'h2);
    check("rs_no_bypass", snp_valid_o, 1'b0);
    check("rs_count1", count_o, 3'd1);
    tick();
    check("rs_issue", snp_valid_o, 1'b1);
    check("rs_addr", snp_addr_o, 64'h8000_1040);
    tick();
    snp_ready_i = 1'b0;
    check("rs_wait_cr_valid", snp_valid_o, 1'b0);
    check("rs_wait_cr_busy", busy_o, 1'b1);
    check("rs_wait_cr_count", count_o, 3'd0);
    cr_done(1'b1);
    check("rs_wait_cd_busy", busy_o, 1'b1);
    cd_beat(1'b0);
    check("rs_nonlast_busy", busy_o, 1'b1);
    cd_beat(1'b1);
    check("rs_idle_busy", busy_o, 1'b0);
    check("rs_valid_once", vcycles, 1);

    // Five back-to-back pushes into a 4-deep queue
    snp_ready_i = 1'b0;
    ac_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ac_addr_i  = 64'h1000 + 64'(i * 64);
      ac_snoop_i = 4'(i + 2);
      ac_prot_i  = 3'(i);
      tick();
    end
    check("full_ac_ready", ac_ready_o, 1'b0);
    check("full_count", count_o, 3'd4);
    ac_addr_i = 64'h1100; ac_snoop_i = 4'hf; ac_prot_i = 3'h7;
    tick(); tick();
    check("full_hold_count", count_o, 3'd4);
    snp_ready_i = 1'b1;
    tick();
    check("first_pop_count", count_o, 3'd3);
    check("first_pop_ready", ac_ready_o, 1'b1);
    tick();
    ac_valid_i = 1'b0;
    check("fifth_push_count", count_o, 3'd4);
    cr_done(1'b0);
    for (int i = 0; i < 4; i++) serve(1'b0);
    check("full_drained", sb.size(), 0);
    check("full_idle_busy", busy_o, 1'b0);

    // MSHR alias holds off issue
    mshr_addr_matches_i = 1'b1;
    snp_ready_i = 1'b1;
    push(64'h40, 4'h7, 3'h1);
    vcycles = 0;
    for (int i = 0; i < 10; i++) tick();
    check("alias_no_valid", vcycles, 0);
    check("alias_mshr_addr", mshr_addr_o, 56'h40);
    mshr_addr_matches_i = 1'b0;
    tick();
    check("alias_issue_next", snp_valid_o, 1'b1);
    tick();
    cr_done(1'b0);

    // CleanInvalid without data, second request one cycle after completion
    snp_ready_i = 1'b0;
    push(64'h2000, 4'h9, 3'h0);
    push(64'h2040, 4'h9, 3'h3);
    snp_ready_i = 1'b1;
    tick();
    cr_done(1'b0);
    check("ci_idle_no_valid", snp_valid_o, 1'b0);
    check("ci_idle_busy", busy_o, 1'b1);
    tick();
    check("ci_reissue", snp_valid_o, 1'b1);
    check("ci_reissue_addr", snp_addr_o, 64'h2040);
    tick();
    cr_done(1'b0);
    check("ci_idle", busy_o, 1'b0);

    // Flush holds off issue
    flush_i = 1'b1;
    push(64'h3000, 4'hb, 3'h4);
    push(64'h3040, 4'hd, 3'h5);
    vcycles = 0;
    for (int i = 0; i < 5; i++) tick();
    check("flush_no_valid", vcycles, 0);
    check("flush_count", count_o, 3'd2);
    flush_i = 1'b0;
    serve(1'b0);
    serve(1'b1);
    check("flush_drained", sb.size(), 0);

    // Reset during WAIT_CD with three queued
    snp_ready_i = 1'b0;
    ac_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ac_addr_i  = 64'h4000 + 64'(i * 64);
      ac_snoop_i = 4'(i);
      ac_prot_i  = 3'(i + 1);
      tick();
    end
    ac_valid_i = 1'b0;
    snp_ready_i = 1'b1;
    tick();
    snp_ready_i = 1'b0;
    cr_done(1'b1);
    check("wcd_count", count_o, 3'd3);
    check("wcd_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    tick();
    sb.delete();
    check("midrst_count", count_o, 3'd0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_ready", ac_ready_o, 1'b0);
    check("midrst_valid", snp_valid_o, 1'b0);
    rst_ni = 1'b1;
    snp_ready_i = 1'b1;
    vcycles = 0;
    for (int i = 0; i < 5; i++) tick();
    check("postrst_no_valid", vcycles, 0);
    check("postrst_ready", ac_ready_o, 1'b1);
    push(64'h5000, 4'h3, 3'h6);
    serve(1'b0);
    check("final_drained", sb.size(), 0);
    check("final_busy", busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
